// File: rtl/lb_pkg.sv
// ---------------------------------------------------------------------------
// lb_pkg
// Shared types and helpers for the line-buffer controller.
//   lb_state_t : controller FSM states
//   KSIZE      : convolution kernel edge length (3x3 window)
//   cnt_w()    : counter width for a range of n values, never below 1 bit
// ---------------------------------------------------------------------------
package lb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } lb_state_t;

    localparam int KSIZE = 3;

    // Width needed to count 0..n-1; guarded so tiny n never yields 0 bits.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
// Column/row position of the next pixel to be accepted in a raster frame.
//   clk, rst     : clock, synchronous active-high reset
//   inc          : advance one pixel (column wraps into the next row)
//   clr_to_col1  : start-of-frame pixel just taken as (0,0); next is (0,1)
//   col, row     : current position
//   last_col     : col is the final column of the row
//   last_pix     : position is the final pixel of the frame
// ---------------------------------------------------------------------------
module raster_counter
    import lb_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc,
    input  logic                       clr_to_col1,
    output logic [cnt_w(WIDTH)-1:0]    col,
    output logic [cnt_w(HEIGHT)-1:0]   row,
    output logic                       last_col,
    output logic                       last_pix
);

    localparam int CW = cnt_w(WIDTH);
    localparam int RW = cnt_w(HEIGHT);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_last_row;

    assign w_last_row = (r_row == RW'(HEIGHT - 1));
    assign last_col   = (r_col == CW'(WIDTH - 1));
    assign last_pix   = last_col && w_last_row;
    assign col        = r_col;
    assign row        = r_row;

    // Position register; the final pixel wraps back to (0,0) so counters never exceed their range.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= CW'(0);
            r_row <= RW'(0);
        end else if (clr_to_col1) begin
            r_col <= CW'(1);
            r_row <= RW'(0);
        end else if (inc) begin
            if (last_col) begin
                r_col <= CW'(0);
                r_row <= w_last_row ? RW'(0) : (r_row + RW'(1));
            end else begin
                r_col <= r_col + CW'(1);
                r_row <= r_row;
            end
        end else begin
            r_col <= r_col;
            r_row <= r_row;
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// line_buffer_ctrl
// Sequences the two cascaded row line buffers feeding a 3x3 convolution
// window from a raster pixel stream.
//   clk, rst            : clock, synchronous active-high reset
//   pix_valid/sof/data  : incoming pixel stream (sof marks pixel (0,0))
//   pix_ready           : a pixel can be accepted this cycle
//   lb_en, lb_d_in      : line-buffer shift enable and data
//   win_valid/ready     : registered window handshake
//   win_col, win_row    : centre coordinate of the valid window
//   frame_done          : one-cycle pulse after the last pixel of a frame
// ---------------------------------------------------------------------------
module line_buffer_ctrl
    import lb_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int DEPTH  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_valid,
    input  logic                      pix_sof,
    input  logic [DEPTH-1:0]          pix_data,
    output logic                      pix_ready,
    output logic                      lb_en,
    output logic [DEPTH-1:0]          lb_d_in,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [cnt_w(WIDTH)-1:0]   win_col,
    output logic [cnt_w(HEIGHT)-1:0]  win_row,
    output logic                      frame_done
);

    localparam int CW = cnt_w(WIDTH);
    localparam int RW = cnt_w(HEIGHT);

    lb_state_t     r_state;
    lb_state_t     w_state_nxt;
    logic          r_win_valid;
    logic [CW-1:0] r_win_col;
    logic [RW-1:0] r_win_row;
    logic          r_frame_done;

    logic          w_pix_ready;
    logic          w_accept;
    logic          w_sof_acc;
    logic          w_counting;
    logic          w_inc;
    logic          w_new_win;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last_col;
    logic          w_last_pix;

    // Single output register with no skid buffer: stall input while a window waits.
    assign w_pix_ready = !r_win_valid || win_ready;
    assign w_accept    = pix_valid && w_pix_ready;
    assign w_sof_acc   = w_accept && pix_sof;
    assign w_counting  = (r_state == FILL) || (r_state == ACTIVE);
    // A sof pixel restarts the frame instead of advancing the old one.
    assign w_inc       = w_accept && !pix_sof && w_counting;
    // Window centre lags the incoming pixel by one row and one column.
    assign w_new_win   = w_accept && !pix_sof && (r_state == ACTIVE)
                         && (w_col >= CW'(KSIZE - 1));

    assign pix_ready  = w_pix_ready;
    assign lb_en      = w_accept && (pix_sof || (r_state != IDLE));
    assign lb_d_in    = pix_data;
    assign win_valid  = r_win_valid;
    assign win_col    = r_win_col;
    assign win_row    = r_win_row;
    assign frame_done = r_frame_done;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster_counter (
        .clk         (clk),
        .rst         (rst),
        .inc         (w_inc),
        .clr_to_col1 (w_sof_acc),
        .col         (w_col),
        .row         (w_row),
        .last_col    (w_last_col),
        .last_pix    (w_last_pix)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an accepted sof overrides every state, including the final pixel.
    always_comb begin
        w_state_nxt = r_state;
        if (w_sof_acc) begin
            w_state_nxt = FILL;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                FILL: begin
                    // Two full rows buffered once the second row's last column lands.
                    if (w_inc && w_last_col && (w_row == RW'(KSIZE - 2))) begin
                        w_state_nxt = ACTIVE;
                    end else begin
                        w_state_nxt = FILL;
                    end
                end
                ACTIVE: begin
                    if (w_inc && w_last_pix) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ACTIVE;
                    end
                end
                DONE: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Window output register: load on a new window, drop once consumed, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_col   <= CW'(0);
            r_win_row   <= RW'(0);
        end else if (w_new_win) begin
            r_win_valid <= 1'b1;
            r_win_col   <= w_col - CW'(1);
            r_win_row   <= w_row - RW'(1);
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
            r_win_col   <= r_win_col;
            r_win_row   <= r_win_row;
        end else begin
            r_win_valid <= r_win_valid;
            r_win_col   <= r_win_col;
            r_win_row   <= r_win_row;
        end
    end

    // frame_done is high exactly while the FSM sits in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (w_state_nxt == DONE);
        end
    end

endmodule
